// File: rtl/adc_data_serializer.sv
// adc_data_serializer: buffers lower/upper ADC results in per-channel FIFOs,
// arbitrates round-robin and shifts framed words out MSB first:
//   start(1), channel, data[15:0], [parity], guard(0).
// Optional feature macro: ADC_SERIALIZER_PARITY_EN (transmit even parity bit).
module adc_data_serializer #(
  parameter int unsigned BIT_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic [15:0] lower_data,
  input  logic        lower_valid,
  input  logic [15:0] upper_data,
  input  logic        upper_valid,
  output logic        serial_out,
  output logic        busy,
  output logic        frame_done,
  output logic        lower_overflow,
  output logic        upper_overflow
);

`ifdef ADC_SERIALIZER_PARITY_EN
  localparam int unsigned FRAME_BITS = 19;
`else
  localparam int unsigned FRAME_BITS = 18;
`endif
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]  CYC_RELOAD = 8'(BIT_CYCLES - 1);
  localparam logic [4:0]  BIT_RELOAD = 5'(FRAME_BITS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GUARD} state_e;

  // Channel index 0 = lower, 1 = upper
  logic [1:0][15:0] in_data;
  logic [1:0]       in_valid;
  logic [1:0][15:0] head;
  logic [1:0]       empty;
  logic [1:0]       ovf;
  logic [1:0]       pop;

  assign in_data  = {upper_data, lower_data};
  assign in_valid = {upper_valid, lower_valid};

  for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;
    logic          ovf_q;
    logic          full;
    logic          push;

    assign full = (cnt_q == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign push = in_valid[ch] & (~full | pop[ch]);

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (push)    wr_q <= wr_q + 1'b1;
        if (pop[ch]) rd_q <= rd_q + 1'b1;
        case ({push, pop[ch]})
          2'b10:   cnt_q <= cnt_q + 1'b1;
          2'b01:   cnt_q <= cnt_q - 1'b1;
          default: cnt_q <= cnt_q;
        endcase
        if (in_valid[ch] && full && !pop[ch]) ovf_q <= 1'b1;
      end
    end

    // Storage array, written on accepted strobes
    always_ff @(posedge clk_in) begin
      if (push) mem_q[wr_q] <= in_data[ch];
    end

    assign empty[ch] = (cnt_q == '0);
    assign head[ch]  = mem_q[rd_q];
    assign ovf[ch]   = ovf_q;
  end

  state_e                  state_q, state_d;
  logic [7:0]              cyc_q, cyc_d;
  logic [4:0]              bit_q, bit_d;
  logic [FRAME_BITS-1:0]   sh_q, sh_d;
  logic                    last_upper_q, last_upper_d;
  logic                    sel_upper;
  logic [15:0]             head_sel;
  logic [FRAME_BITS-1:0]   frame_word;

  // Serve the channel not served last when both wait, else whichever waits
  assign sel_upper = ~empty[1] & (empty[0] | ~last_upper_q);
  assign head_sel  = head[sel_upper];
`ifdef ADC_SERIALIZER_PARITY_EN
  assign frame_word = {1'b1, sel_upper, head_sel, ^head_sel};
`else
  assign frame_word = {1'b1, sel_upper, head_sel};
`endif

  // FSM, counters and shift register state
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cyc_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      last_upper_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      last_upper_q <= last_upper_d;
    end
  end

  // Next-state: LOAD pops, SHIFT/GUARD count BIT_CYCLES per bit period
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    last_upper_d = last_upper_q;
    pop          = '0;
    case (state_q)
      ST_IDLE: begin
        if (empty != 2'b11) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        pop          = sel_upper ? 2'b10 : 2'b01;
        last_upper_d = sel_upper;
        sh_d         = frame_word;
        cyc_d        = CYC_RELOAD;
        bit_d        = BIT_RELOAD;
        state_d      = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cyc_q == '0) begin
          cyc_d = CYC_RELOAD;
          if (bit_q == '0) begin
            state_d = ST_GUARD;
          end else begin
            bit_d = bit_q - 1'b1;
            sh_d  = sh_q << 1;
          end
        end else begin
          cyc_d = cyc_q - 1'b1;
        end
      end
      ST_GUARD: begin
        if (cyc_q == '0) state_d = (empty != 2'b11) ? ST_LOAD : ST_IDLE;
        else             cyc_d   = cyc_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign serial_out     = (state_q == ST_SHIFT) & sh_q[FRAME_BITS-1];
  assign busy           = (state_q == ST_SHIFT) | (state_q == ST_GUARD);
  assign frame_done     = (state_q == ST_GUARD) & (cyc_q == '0);
  assign lower_overflow = ovf[0];
  assign upper_overflow = ovf[1];

endmodule
